// File: rtl/psum_wb_acc_pkg.sv
// Shared codes for the partial-sum write-back path: layer codes, reset levels,
// FSM state encoding and int8 saturation bounds.
package psum_wb_acc_pkg;

  localparam logic [3:0] Layer1 = 4'd1;
  localparam logic [3:0] Layer2 = 4'd2;
  localparam logic [3:0] Layer3 = 4'd3;
  localparam logic [3:0] Layer4 = 4'd4;
  localparam logic [3:0] Layer5 = 4'd5;

  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic signed [7:0] Int8Max = 8'sh7f;
  localparam logic signed [7:0] Int8Min = 8'sh80;

endpackage

// File: rtl/psum_wb_acc_requant.sv
// psum_requant: one-lane round-half-up right shift, int8 saturation and
// (with PSUM_RELU_EN defined) optional clamp of negative results to zero.
module psum_requant
  import psum_wb_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] i_total,
  input  logic        [4:0]       i_shift,
`ifdef PSUM_RELU_EN
  input  logic                    i_relu,
`endif
  output logic signed [7:0]       o_byte
);

  // Wide enough that the rounding term never overflows for any 5-bit shift.
  localparam int unsigned EW = ACC_W + 33;

  logic signed [EW-1:0] w_ext;
  logic signed [EW-1:0] w_rnd;
  logic signed [EW-1:0] w_v;

  always_comb begin
    w_ext = EW'(i_total);
    w_rnd = '0;
    if (i_shift != 5'd0) begin
      w_rnd = EW'(1) << (i_shift - 5'd1);
    end
    w_v = (w_ext + w_rnd) >>> i_shift;
    if (w_v > EW'(Int8Max)) begin
      o_byte = Int8Max;
    end else if (w_v < EW'(Int8Min)) begin
      o_byte = Int8Min;
    end else begin
      o_byte = w_v[7:0];
    end
`ifdef PSUM_RELU_EN
    if (i_relu && o_byte[7]) begin
      o_byte = '0;
    end
`endif
  end

endmodule

// File: rtl/psum_wb_acc.sv
// psum_wb_acc: accumulates PE-group partial sums across input-channel passes and
// writes requantized int8 results on the final pass. PSUM_RELU_EN adds i_cfg_relu.
module psum_wb_acc
  import psum_wb_acc_pkg::*;
#(
  parameter int unsigned PSUM_W = 19,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic        [3:0]        i_layer,
  input  logic        [8:0]        i_cfg_npos,
  input  logic        [7:0]        i_cfg_npass,
  input  logic        [4:0]        i_cfg_shift,
  input  logic        [ADDR_W-1:0] i_cfg_base,
`ifdef PSUM_RELU_EN
  input  logic                     i_cfg_relu,
`endif
  input  logic                     i_wb_en,
  input  logic signed [PSUM_W-1:0] i_groupsum_in1,
  input  logic signed [PSUM_W-1:0] i_groupsum_in2,
  output logic                     o_ofmap_we,
  output logic        [ADDR_W-1:0] o_ofmap_addr,
  output logic signed [7:0]        o_ofmap_wdata1,
  output logic signed [7:0]        o_ofmap_wdata2,
  output logic        [1:0]        o_ofmap_wmask,
  output logic                     o_busy,
  output logic                     o_finish,
  output logic                     o_acc_ovf
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  state_e r_state, w_state_nxt;

  logic        [8:0]        r_pos, r_npos;
  logic        [7:0]        r_pass, r_npass;
  logic        [4:0]        r_shift;
  logic        [ADDR_W-1:0] r_base;
  logic                     r_single;
  logic                     r_ovf;
  logic                     r_we;
  logic        [ADDR_W-1:0] r_addr;
  logic signed [7:0]        r_wd1, r_wd2;
  logic        [1:0]        r_mask;
`ifdef PSUM_RELU_EN
  logic                     r_relu;
`endif

  logic signed [ACC_W-1:0] r_acc [2][DEPTH];

  logic                     w_beat, w_first, w_final, w_pos_last, w_ovf_hit;
  logic        [IDX_W-1:0]  w_idx;
  logic signed [PSUM_W-1:0] w_ps  [2];
  logic signed [ACC_W-1:0]  w_ext [2];
  logic signed [ACC_W-1:0]  w_tot [2];
  logic signed [ACC_W:0]    w_sum [2];
  logic        [1:0]        w_ovf;
  logic signed [7:0]        w_q1, w_q2;

  // Beats are dropped once the last pass has completed (pass == npass).
  assign w_beat     = (r_state == StAccum) && i_wb_en && (r_pass != r_npass);
  assign w_first    = (r_pass == 8'd0);
  assign w_final    = (r_pass == (r_npass - 8'd1));
  assign w_pos_last = (r_pos == (r_npos - 9'd1));
  assign w_idx      = r_pos[IDX_W-1:0];
  assign w_ps[0]    = i_groupsum_in1;
  assign w_ps[1]    = i_groupsum_in2;
  assign w_ovf_hit  = w_beat && !w_first && (w_ovf[0] || (w_ovf[1] && !r_single));

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      w_ext[l] = ACC_W'(w_ps[l]);
      w_sum[l] = (ACC_W+1)'(r_acc[l][w_idx]) + (ACC_W+1)'(w_ext[l]);
      w_ovf[l] = 1'b0;
      if (w_first) begin
        w_tot[l] = w_ext[l];
      end else if (w_sum[l][ACC_W] != w_sum[l][ACC_W-1]) begin
        w_ovf[l] = 1'b1;
        w_tot[l] = w_sum[l][ACC_W] ? AccMin : AccMax;
      end else begin
        w_tot[l] = w_sum[l][ACC_W-1:0];
      end
    end
  end

  psum_requant #(
    .ACC_W(ACC_W)
  ) u_rq1 (
    .i_total(w_tot[0]),
    .i_shift(r_shift),
`ifdef PSUM_RELU_EN
    .i_relu (r_relu),
`endif
    .o_byte (w_q1)
  );

  psum_requant #(
    .ACC_W(ACC_W)
  ) u_rq2 (
    .i_total(w_tot[1]),
    .i_shift(r_shift),
`ifdef PSUM_RELU_EN
    .i_relu (r_relu),
`endif
    .o_byte (w_q2)
  );

  always_ff @(posedge i_clk) begin
    if (w_beat && !w_final) begin
      r_acc[0][w_idx] <= w_tot[0];
      r_acc[1][w_idx] <= w_tot[1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt = (i_cfg_npos == 9'd0 || i_cfg_npass == 8'd0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        // Leaves one cycle after the last beat so finish follows the last write.
        if (r_pass == r_npass) begin
          w_state_nxt = StDone;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_busy   = 1'b0;
    o_finish = 1'b0;
    unique case (r_state)
      StAccum: o_busy   = 1'b1;
      StDone:  o_finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos    <= '0;
      r_npos   <= '0;
      r_pass   <= '0;
      r_npass  <= '0;
      r_shift  <= '0;
      r_base   <= '0;
      r_single <= 1'b0;
      r_ovf    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wd1    <= '0;
      r_wd2    <= '0;
      r_mask   <= '0;
`ifdef PSUM_RELU_EN
      r_relu   <= 1'b0;
`endif
    end else begin
      r_we <= 1'b0;
      if (r_state == StIdle && i_start) begin
        r_npos   <= i_cfg_npos;
        r_npass  <= i_cfg_npass;
        r_shift  <= i_cfg_shift;
        r_base   <= i_cfg_base;
        r_single <= (i_layer == Layer1);
        r_pos    <= '0;
        r_pass   <= '0;
        r_ovf    <= 1'b0;
`ifdef PSUM_RELU_EN
        r_relu   <= i_cfg_relu;
`endif
      end
      if (w_beat) begin
        if (w_pos_last) begin
          r_pos  <= '0;
          r_pass <= r_pass + 8'd1;
        end else begin
          r_pos <= r_pos + 9'd1;
        end
        if (w_ovf_hit) begin
          r_ovf <= 1'b1;
        end
        if (w_final) begin
          r_we   <= 1'b1;
          r_addr <= r_base + ADDR_W'(r_pos);
          r_wd1  <= w_q1;
          r_wd2  <= r_single ? 8'sd0 : w_q2;
          r_mask <= r_single ? 2'b01 : 2'b11;
        end
      end
    end
  end

  assign o_ofmap_we     = r_we;
  assign o_ofmap_addr   = r_addr;
  assign o_ofmap_wdata1 = r_wd1;
  assign o_ofmap_wdata2 = r_wd2;
  assign o_ofmap_wmask  = r_mask;
  assign o_acc_ovf      = r_ovf;

endmodule

// File: tb/tb_psum_wb_acc.sv
// Self-checking bench for psum_wb_acc: directed and random tiles against a
// per-position arithmetic model of accumulate / round / saturate / write.
module tb_psum_wb_acc;
  import psum_wb_acc_pkg::*;

  localparam int PSUM_W = 19;
  localparam int ACC_W  = 24;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 256;
  localparam longint AMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (ACC_W - 1));

  logic clk = 1'b0;
  logic rst_n;
  logic start, wb_en;
  logic [3:0] layer;
  logic [8:0] npos;
  logic [7:0] npass;
  logic [4:0] shift;
  logic [ADDR_W-1:0] base;
  logic signed [PSUM_W-1:0] gs1, gs2;
  logic we, busy, finish, ovf;
  logic [ADDR_W-1:0] addr;
  logic signed [7:0] wd1, wd2;
  logic [1:0] mask;
`ifdef PSUM_RELU_EN
  logic relu;
`endif

  psum_wb_acc #(
    .PSUM_W(PSUM_W),
    .ACC_W (ACC_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_layer       (layer),
    .i_cfg_npos    (npos),
    .i_cfg_npass   (npass),
    .i_cfg_shift   (shift),
    .i_cfg_base    (base),
`ifdef PSUM_RELU_EN
    .i_cfg_relu    (relu),
`endif
    .i_wb_en       (wb_en),
    .i_groupsum_in1(gs1),
    .i_groupsum_in2(gs2),
    .o_ofmap_we    (we),
    .o_ofmap_addr  (addr),
    .o_ofmap_wdata1(wd1),
    .o_ofmap_wdata2(wd2),
    .o_ofmap_wmask (mask),
    .o_busy        (busy),
    .o_finish      (finish),
    .o_acc_ovf     (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] addr;
    logic signed [31:0] d1;
    logic signed [31:0] d2;
    logic signed [31:0] mask;
    logic signed [31:0] cyc;
  } wr_t;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  wr_t wr_q[$];
  wr_t ex_q[$];
  wr_t mon_w;
  wr_t exp_w;
  int  fin_q[$];
  int  beat_cyc[$];
  int  g1[$];
  int  g2[$];
  int  ex_ovf;
  int  t_start;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      mon_w.addr = 32'(addr);
      mon_w.d1   = 32'(wd1);
      mon_w.d2   = 32'(wd2);
      mon_w.mask = 32'(mask);
      mon_w.cyc  = cyc;
      wr_q.push_back(mon_w);
    end
    if (finish === 1'b1) fin_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rq(input longint t, input int sh, input bit rl);
    longint v;
    v = (sh == 0) ? t : ((t + (longint'(1) <<< (sh - 1))) >>> sh);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    if (rl && v < 0) v = 0;
    return int'(v);
  endfunction

  // Expected writes: one per position, totals summed over passes with clamping.
  function automatic void model_tile(input int np, input int nps, input int sh, input int bs,
                                     input bit single, input bit rl);
    longint t0, t1;
    wr_t w;
    ex_q.delete();
    ex_ovf = 0;
    for (int p = 0; p < np; p++) begin
      t0 = 0;
      t1 = 0;
      for (int k = 0; k < nps; k++) begin
        if (k == 0) begin
          t0 = g1[p];
          t1 = g2[p];
        end else begin
          t0 += g1[k * np + p];
          t1 += g2[k * np + p];
          if (t0 > AMAX) begin t0 = AMAX; ex_ovf = 1; end
          if (t0 < AMIN) begin t0 = AMIN; ex_ovf = 1; end
          if (t1 > AMAX) begin t1 = AMAX; if (!single) ex_ovf = 1; end
          if (t1 < AMIN) begin t1 = AMIN; if (!single) ex_ovf = 1; end
        end
      end
      w.addr = (bs + p) % (1 << ADDR_W);
      w.d1   = rq(t0, sh, rl);
      w.d2   = single ? 0 : rq(t1, sh, rl);
      w.mask = single ? 1 : 3;
      w.cyc  = 0;
      ex_q.push_back(w);
    end
  endfunction

  task automatic fill_rand(input int n);
    g1.delete();
    g2.delete();
    for (int i = 0; i < n; i++) begin
      g1.push_back(int'($urandom) >>> 13);
      g2.push_back(int'($urandom) >>> 13);
    end
  endtask

  task automatic run_tile(input int np, input int nps, input int sh, input int bs,
                          input logic [3:0] lay, input bit rl, input bit gaps,
                          input bit inject);
    int idx;
    model_tile(np, nps, sh, bs, (lay == Layer1), rl);
    wr_q.delete();
    fin_q.delete();
    beat_cyc.delete();
    @(negedge clk);
    layer = lay;
    npos  = 9'(np);
    npass = 8'(nps);
    shift = 5'(sh);
    base  = ADDR_W'(bs);
    start = 1'b1;
`ifdef PSUM_RELU_EN
    relu = rl;
`endif
    @(negedge clk);
    start = 1'b0;
    npos  = 9'($urandom);
    npass = 8'($urandom);
    shift = 5'($urandom);
    base  = ADDR_W'($urandom);
    layer = 4'($urandom);
    chk("busy_after_start", 32'(busy), 1);
    for (int k = 0; k < nps; k++) begin
      for (int p = 0; p < np; p++) begin
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        idx   = k * np + p;
        wb_en = 1'b1;
        gs1   = PSUM_W'(g1[idx]);
        gs2   = PSUM_W'(g2[idx]);
        if (k == nps - 1) beat_cyc.push_back(cyc);
        if (inject && k == 0 && p == 0) begin
          start = 1'b1;
          npass = 8'd0;
          npos  = 9'd1;
        end
        @(negedge clk);
        wb_en = 1'b0;
        start = 1'b0;
        gs1   = PSUM_W'($urandom);
        gs2   = PSUM_W'($urandom);
      end
    end
    for (int i = 0; i < 20 && fin_q.size() == 0; i++) begin
      @(negedge clk);
      #2;
    end
    repeat (3) @(negedge clk);
    #2;
    chk("finish_count", fin_q.size(), 1);
    chk("write_count", wr_q.size(), ex_q.size());
    for (int i = 0; i < wr_q.size() && i < ex_q.size(); i++) begin
      exp_w = ex_q[i];
      chk("wr_addr", wr_q[i].addr, exp_w.addr);
      chk("wr_data1", wr_q[i].d1, exp_w.d1);
      chk("wr_data2", wr_q[i].d2, exp_w.d2);
      chk("wr_mask", wr_q[i].mask, exp_w.mask);
      chk("wr_cycle", wr_q[i].cyc, beat_cyc[i] + 1);
    end
    if (fin_q.size() > 0) chk("finish_cycle", fin_q[0], beat_cyc[beat_cyc.size() - 1] + 2);
    chk("acc_ovf", 32'(ovf), ex_ovf);
    chk("busy_end", 32'(busy), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_wd1"}, 32'(wd1), 0);
    chk({tag, "_wd2"}, 32'(wd2), 0);
    chk({tag, "_mask"}, 32'(mask), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_finish"}, 32'(finish), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  initial begin
    rst_n = RstEnable;
    start = 1'b0;
    wb_en = 1'b0;
    layer = Layer2;
    npos  = '0;
    npass = '0;
    shift = '0;
    base  = '0;
    gs1   = '0;
    gs2   = '0;
`ifdef PSUM_RELU_EN
    relu = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = RstDisable;

    // Dual lane, single pass, int8 clamping at shift 0.
    g1 = '{10, 127, 200, 0};
    g2 = '{-5, -128, -300, 1};
    run_tile(4, 1, 0, 100, Layer3, 1'b0, 1'b1, 1'b0);

    // Single lane, three passes, rounding shift of 2.
    g1 = '{5, 7, 5, 7, 6, 6};
    g2 = '{100, -100, 50, 50, 9, 9};
    run_tile(2, 3, 2, 7, Layer1, 1'b0, 1'b1, 1'b0);

    // Accumulator saturation both directions over many passes.
    g1.delete();
    g2.delete();
    for (int i = 0; i < 40; i++) begin
      g1.push_back(262143);
      g2.push_back(-262144);
    end
    run_tile(1, 40, 0, 3, Layer2, 1'b0, 1'b0, 1'b0);

    // Full depth, back-to-back beats, address wrap past 2^ADDR_W-1.
    fill_rand(2 * DEPTH);
    run_tile(DEPTH, 2, 10, 900, Layer2, 1'b0, 1'b0, 1'b0);

    // Zero passes: finish one cycle after start, no writes.
    wr_q.delete();
    fin_q.delete();
    @(negedge clk);
    npos    = 9'd5;
    npass   = 8'd0;
    start   = 1'b1;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("npass0_finish_count", fin_q.size(), 1);
    if (fin_q.size() > 0) chk("npass0_finish_cycle", fin_q[0], t_start + 1);
    chk("npass0_writes", wr_q.size(), 0);

    // Start pulse while busy is ignored.
    fill_rand(6);
    run_tile(3, 2, 4, 50, Layer4, 1'b0, 1'b1, 1'b1);

    // Reset during the second pass aborts the tile.
    fill_rand(9);
    @(negedge clk);
    layer = Layer2;
    npos  = 9'd3;
    npass = 8'd3;
    shift = 5'd1;
    base  = ADDR_W'(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_en = 1'b1;
      gs1   = PSUM_W'(g1[i]);
      gs2   = PSUM_W'(g2[i]);
      @(negedge clk);
    end
    #1;
    rst_n = RstEnable;
    #1;
    chk_outputs_zero("midreset");
    wb_en = 1'b0;
    wr_q.delete();
    fin_q.delete();
    @(negedge clk);
    rst_n = RstDisable;
    repeat (6) @(negedge clk);
    #2;
    chk("midreset_writes", wr_q.size(), 0);
    chk("midreset_finish", fin_q.size(), 0);
    fill_rand(8);
    run_tile(4, 2, 3, 1020, Layer5, 1'b0, 1'b1, 1'b0);

`ifdef PSUM_RELU_EN
    g1 = '{-9};
    g2 = '{0};
    run_tile(1, 1, 0, 11, Layer1, 1'b1, 1'b0, 1'b0);
    fill_rand(12);
    run_tile(4, 3, 6, 200, Layer2, 1'b1, 1'b1, 1'b0);
`endif

    // Random tiles across layers, shifts and bases.
    for (int r = 0; r < 6; r++) begin
      int np, nps;
      np  = $urandom_range(1, 20);
      nps = $urandom_range(1, 4);
      fill_rand(np * nps);
      run_tile(np, nps, $urandom_range(0, 20), $urandom_range(0, 1023),
               4'($urandom_range(1, 5)), 1'b0, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
